// File: rtl/serdes_arb_pkg.sv
// serdes_arb_pkg: shared state encoding and default widths for the serial link arbiter
package serdes_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int N_SAMPLES_DEF = 8;
  localparam int REQ_W = $clog2(N_REQ_DEF);
  localparam int CNT_W = $clog2(N_SAMPLES_DEF);
endpackage

// File: rtl/serial_link_arbiter_rr_picker.sv
// rr_picker: round-robin priority encoder (req, prio in; any, idx = first req at or after prio out)
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int REQ_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [REQ_W-1:0] prio,
  output logic             any,
  output logic [REQ_W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(prio) + k) % N_REQ]) idx = REQ_W'((int'(prio) + k) % N_REQ);
  end
endmodule

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter: atomic N_SAMPLES-word round-robin bursts from N_REQ channels onto one link (clk, reset, recv_msg/val/rdy in, send_msg/val/rdy/src/last out)
module serial_link_arbiter
  import serdes_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_REQ = N_REQ_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ*BIT_WIDTH-1:0]   recv_msg,
  input  logic [N_REQ-1:0]             recv_val,
  output logic [N_REQ-1:0]             recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic [$clog2(N_REQ)-1:0]     send_src,
  output logic                         send_last
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(N_SAMPLES);
  state_t state, state_nx;
  logic [GW-1:0] grant, grant_nx, prio, prio_nx, pick;
  logic [CW-1:0] count, count_nx;
  logic any, busy, xfer, term;
  rr_picker #(.N_REQ(N_REQ), .REQ_W(GW)) u_pick (
    .req (recv_val),
    .prio(prio),
    .any (any),
    .idx (pick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      prio  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      prio  <= prio_nx;
      count <= count_nx;
    end
  always_comb begin
    busy      = state == BURST;
    send_msg  = recv_msg[int'(grant)*BIT_WIDTH +: BIT_WIDTH];
    send_src  = grant;
    send_val  = busy & recv_val[grant];
    xfer      = send_val & send_rdy;
    term      = count == CW'(N_SAMPLES - 1);
    send_last = term & send_val;
    recv_rdy  = (busy & send_rdy) ? N_REQ'(1) << grant : '0;
    state_nx  = state;
    grant_nx  = grant;
    prio_nx   = prio;
    count_nx  = count;
    if (!busy && any) begin
      state_nx = BURST;
      grant_nx = pick;
      count_nx = '0;
    end else if (xfer) begin
      count_nx = term ? '0 : count + 1'b1;
      if (term) begin
        state_nx = IDLE;
        prio_nx  = grant == GW'(N_REQ - 1) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_link_arbiter.sv
// tb_serial_link_arbiter: directed and random checks of serial_link_arbiter against a burst-level model
module tb_serial_link_arbiter;
  localparam int BW = 32, NR = 4, NS = 8;
  logic clk = 0, reset = 1, reset5 = 1;
  always #5 clk = ~clk;
  logic [NR*BW-1:0] recv_msg = '0;
  logic [NR-1:0] recv_val = '0, recv_rdy;
  logic [BW-1:0] send_msg;
  logic send_val, send_rdy = 0, send_last;
  logic [1:0] send_src;
  logic [3*BW-1:0] msg5 = '0;
  logic [2:0] val5 = '1, rdy5;
  logic [BW-1:0] smsg5;
  logic sval5, slast5;
  logic [1:0] ssrc5;
  serial_link_arbiter #(.BIT_WIDTH(BW), .N_REQ(NR), .N_SAMPLES(NS)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy), .send_src(send_src), .send_last(send_last)
  );
  serial_link_arbiter #(.BIT_WIDTH(BW), .N_REQ(3), .N_SAMPLES(5)) u5 (
    .clk(clk), .reset(reset5), .recv_msg(msg5), .recv_val(val5), .recv_rdy(rdy5),
    .send_msg(smsg5), .send_val(sval5), .send_rdy(1'b1), .send_src(ssrc5), .send_last(slast5)
  );
  int checks = 0, errors = 0;
  bit m_busy = 0, rnd = 0;
  int m_owner = 0, m_sent = 0, m_prio = 0, m_bursts = 0, obs_x = 0, gap = 0;
  int g_log[$];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0;
    m_prio = 0;
    m_sent = 0;
  endtask
  task automatic cycle();
    for (int i = 0; i < NR; i++)
      recv_msg[i*BW +: BW] = rnd ? BW'($urandom) : BW'((i << 24) | m_sent);
    #1;
    chk("send_val", send_val, m_busy && recv_val[m_owner]);
    chk("recv_rdy", recv_rdy, (m_busy && send_rdy) ? (1 << m_owner) : 0);
    chk("send_last", send_last, m_busy && recv_val[m_owner] && m_sent == NS - 1);
    if (m_busy) chk("send_src", send_src, m_owner);
    if (m_busy && recv_val[m_owner]) chk("send_msg", send_msg, recv_msg[m_owner*BW +: BW]);
    if (send_val && send_rdy) obs_x++;
    @(posedge clk);
    if (!reset) model_reset();
    else if (!m_busy) begin
      for (int k = 0; k < NR; k++)
        if (recv_val[(m_prio + k) % NR]) begin
          m_busy = 1;
          m_owner = (m_prio + k) % NR;
          m_sent = 0;
          g_log.push_back(m_owner);
          break;
        end
    end else if (recv_val[m_owner] && send_rdy) begin
      m_sent++;
      if (m_sent == NS) begin
        m_busy = 0;
        m_prio = (m_owner + 1) % NR;
        m_bursts++;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 0;
    recv_val = '0;
    send_rdy = 0;
    model_reset();
    repeat (2) cycle();
    reset = 1;
    g_log.delete();
    obs_x = 0;
    m_bursts = 0;
  endtask
  initial begin
    int w, nb;
    #1 reset = 0;
    reset5 = 0;
    do_reset();
    chk("rst_src", send_src, 0);
    chk("rst_prio", dut.prio, 0);
    chk("rst_state", dut.state, serdes_arb_pkg::IDLE);
    recv_val = 4'b0100;
    send_rdy = 1;
    repeat (9) cycle();
    chk("single_words", obs_x, 8);
    chk("single_grant", g_log[0], 2);
    chk("single_prio", dut.prio, 3);
    recv_val = '0;
    cycle();
    do_reset();
    recv_val = '1;
    send_rdy = 1;
    repeat (45) cycle();
    chk("all_n", g_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("all_order", g_log[i], i % NR);
    do_reset();
    recv_val = 4'b0100;
    send_rdy = 1;
    repeat (9) cycle();
    g_log.delete();
    recv_val = 4'b1001;
    repeat (18) cycle();
    chk("wrap_n", g_log.size(), 2);
    chk("wrap_first", g_log[0], 3);
    chk("wrap_second", g_log[1], 0);
    recv_val = 4'b0010;
    repeat (9) cycle();
    g_log.delete();
    recv_val = 4'b0011;
    repeat (9) cycle();
    chk("prio2_n", g_log.size(), 1);
    chk("prio2_grant", g_log[0], 0);
    do_reset();
    gap = 0;
    for (int i = 0; i < 60 && m_bursts == 0; i++) begin
      send_rdy = (i % 3) != 1;
      recv_val = '1;
      if (m_busy && m_sent == 4 && gap < 3) begin
        recv_val[m_owner] = 0;
        gap++;
      end
      cycle();
    end
    chk("stall_done", m_bursts, 1);
    chk("stall_words", obs_x, 8);
    chk("stall_gap", gap, 3);
    chk("stall_grant", g_log[0], 0);
    do_reset();
    recv_val = 4'b0100;
    send_rdy = 1;
    repeat (6) cycle();
    chk("pre_rst_count", dut.count, 5);
    #1 reset = 0;
    model_reset();
    #1;
    chk("arst_val", send_val, 0);
    chk("arst_rdy", recv_rdy, 0);
    chk("arst_prio", dut.prio, 0);
    chk("arst_state", dut.state, serdes_arb_pkg::IDLE);
    cycle();
    reset = 1;
    obs_x = 0;
    m_bursts = 0;
    repeat (9) cycle();
    chk("restart_words", obs_x, 8);
    chk("restart_done", m_bursts, 1);
    do_reset();
    rnd = 1;
    repeat (500) begin
      recv_val = NR'($urandom);
      send_rdy = $urandom_range(0, 3) != 0;
      cycle();
    end
    rnd = 0;
    reset5 = 1;
    w = 0;
    nb = 0;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      @(negedge clk);
      if (sval5) begin
        w++;
        if (slast5) begin
          chk("n5_words", w, 5);
          chk("n5_src", ssrc5, nb % 3);
          w = 0;
          nb++;
        end
      end
    end
    chk("n5_bursts", nb, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_link_arbiter.md
Name: serial_link_arbiter

Overview:
Shares one downstream serial word link between N_REQ serializer channels. Grants the link to one requester for an atomic burst of N_SAMPLES words, which is one full serialized frame. Grants rotate round-robin. Sits between the per-channel serializers and the single SERDES output lane, and tags each word with its source channel.

Parameters:
BIT_WIDTH, 32, word width of every message
N_REQ, 4, number of requesting serializer channels (>=2)
N_SAMPLES, 8, words per burst/frame (>=2, need not be a power of 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
recv_msg  input  N_REQ x BIT_WIDTH  per-requester word
recv_val  input  N_REQ  per-requester valid
recv_rdy  output  N_REQ  per-requester ready
send_msg  output  BIT_WIDTH  word to link
send_val  output  1  link valid
send_rdy  input  1  link ready
send_src  output  $clog2(N_REQ)  index of the granted requester
send_last  output  1  high on the final word of a burst

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - state=IDLE, grant=0, prio=0, count=0.
  - Outputs: send_val=0, recv_rdy=all 0, send_last=0, send_src=0, send_msg=recv_msg[0] (don't-care while send_val=0).
- State IDLE:
  - Drives send_val=0 and recv_rdy=all 0.
  - If any recv_val is set, grant <= first requester with recv_val set, searching prio, prio+1, ... mod N_REQ.
  - Then: count <= 0, state <= BURST. If no recv_val is set, stay in IDLE.
- State BURST:
  - send_msg=recv_msg[grant], send_val=recv_val[grant], send_src=grant.
  - recv_rdy[grant]=send_rdy; all other recv_rdy=0.
  - Transfer = recv_val[grant] & send_rdy. Each transfer increments count.
  - send_last = (count==N_SAMPLES-1) & send_val.
  - On the transfer where count==N_SAMPLES-1: state <= IDLE, count <= 0, prio <= (grant+1) mod N_REQ (wrap N_REQ-1 -> 0).
- Latency: first word can transfer 1 cycle after the request is seen in IDLE. There is exactly 1 IDLE bubble cycle between consecutive bursts.
- Stalls:
  - recv_val[grant] low mid-burst: send_val drops, count and grant are held, and the link is not released. Burst atomicity is guaranteed.
  - send_rdy low: count is held and the word is held.
- Requests from non-granted channels during BURST are ignored until IDLE; their recv_rdy stays 0.
- Simultaneous requests in IDLE: the lowest index at or after prio (with wrap) wins.
- A requester dropping recv_val in IDLE before being granted is not latched; only the current cycle's recv_val counts.
- Reset mid-burst: the burst is aborted immediately and the partial frame is discarded downstream. prio returns to 0.
- count width is $clog2(N_SAMPLES). The terminal compare is against N_SAMPLES-1, never against overflow.
- send_msg, send_val, send_src and send_last are combinational from state, grant and count. recv_rdy is combinational from send_rdy.

Decomposition:
- Package serdes_arb_pkg holds:
  - state enum {IDLE, BURST}
  - localparams REQ_W=$clog2(N_REQ) and CNT_W=$clog2(N_SAMPLES)
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req[N_REQ], prio.
  - Outputs: any, idx.
- The controller FSM, the counter and the grant/prio registers live in serial_link_arbiter.

Test Plan:
- Single requester: reset, then recv_val=4'b0100 with send_rdy=1. Expect:
  - 1 IDLE cycle.
  - 8 transfers with send_src=2 and send_msg equal to channel 2's words in order.
  - send_last on the 8th transfer only.
  - Back to IDLE; prio=3.
- All four requesting continuously from reset: grant order is 0,1,2,3,0. Each burst is 8 words, and there is exactly 1 bubble cycle between bursts.
- Wrap: prio=3 with requests 4'b1001. Grant goes to 3, then to 0. Requests 4'b0011 with prio=2 grant 0.
- Stalls mid-burst:
  - Toggle send_rdy 1,0,1 and drop recv_val[grant] at word 4 for 3 cycles.
  - Expect count held, send_val=0 during the val gap, no grant change even with other requests pending, and still exactly 8 words.
- Reset mid-burst: assert reset after word 5. Expect send_val=0 and recv_rdy=0 asynchronously, state IDLE, prio=0. After release, a new request restarts at word count 0.
- N_SAMPLES=5, N_REQ=3 build: verify send_last on the 5th word and round-robin 0,1,2,0 with no counter overflow.
